// File: rtl/aip_responder.sv
// AIP register-mapped responder: input/output buffers, CFG/STATUS registers and core launch FSM.
// Optional ID register at 0x1E is enabled by defining AIP_RESPONDER_ID_EN.
module aip_responder (
  input  logic        clk_clk,
  input  logic        reset,
  input  logic [4:0]  aip_config,
  input  logic [31:0] aip_datain,
  input  logic        aip_write,
  input  logic        aip_read,
  input  logic        aip_start,
  input  logic        core_int,
  output logic [31:0] aip_dataout,
  output logic        aip_int,
  output logic        core_start,
  output logic [31:0] core_cfg,
  input  logic        core_done,
  input  logic        core_busy,
  input  logic [3:0]  in_rdaddr,
  output logic [31:0] in_rddata,
  input  logic        out_we,
  input  logic [3:0]  out_wraddr,
  input  logic [31:0] out_wrdata
);

  localparam logic [4:0] ADDR_MEM_IN  = 5'h00;
  localparam logic [4:0] ADDR_MEM_OUT = 5'h01;
  localparam logic [4:0] ADDR_CFG     = 5'h02;
  localparam logic [4:0] ADDR_ID      = 5'h1E;
  localparam logic [4:0] ADDR_STATUS  = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] in_mem  [16];
  logic [31:0] out_mem [16];
  logic [3:0]  in_wptr;
  logic [3:0]  out_rptr;
  logic [2:0]  in_count;
  logic        in_wrapped;
  logic        ovf;
  logic [31:0] cfg_q;
  logic [31:0] status;
  logic [31:0] read_mux;

  logic wr_mem_in, rd_mem_out, wr_cfg, wr_status, status_ack, start_go;

  assign wr_mem_in  = aip_write && (aip_config == ADDR_MEM_IN);
  assign rd_mem_out = aip_read  && (aip_config == ADDR_MEM_OUT);
  assign wr_cfg     = aip_write && (aip_config == ADDR_CFG);
  assign wr_status  = aip_write && (aip_config == ADDR_STATUS);
  assign status_ack = wr_status && aip_datain[1];
  assign start_go   = (state_q == ST_IDLE) && aip_start && !core_busy;

  assign status    = {26'b0, ovf, core_busy, (state_q == ST_DONE), in_count};
  assign aip_int   = (state_q == ST_DONE);
  assign core_cfg  = cfg_q;
  assign in_rddata = in_mem[in_rdaddr];

  // Acknowledge wins over a simultaneous core_done because DONE only looks at the ack.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_go)                state_d = ST_RUN;
      ST_RUN:  if (core_done)               state_d = ST_DONE;
      ST_DONE: if (core_int || status_ack)  state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    read_mux = 32'h0;
    unique case (aip_config)
      ADDR_MEM_OUT: read_mux = out_mem[out_rptr];
      ADDR_CFG:     read_mux = cfg_q;
`ifdef AIP_RESPONDER_ID_EN
      ADDR_ID:      read_mux = 32'h00A1_2001;
`else
      ADDR_ID:      read_mux = 32'h0;
`endif
      ADDR_STATUS:  read_mux = status;
      default:      read_mux = 32'h0;
    endcase
  end

  // NOTE: state and registers use non-blocking assignments so every flop samples pre-edge values;
  // that is also what makes a same-cycle CFG read return the old contents.
  always_ff @(posedge clk_clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_clk or posedge reset) begin
    if (reset) begin
      in_wptr     <= 4'd0;
      out_rptr    <= 4'd0;
      in_count    <= 3'd0;
      in_wrapped  <= 1'b0;
      ovf         <= 1'b0;
      cfg_q       <= 32'h0;
      aip_dataout <= 32'h0;
      core_start  <= 1'b0;
    end else begin
      core_start <= start_go;
      if (wr_cfg) cfg_q <= aip_datain;
      if (aip_read) aip_dataout <= read_mux;

      if (start_go) begin
        in_wptr    <= 4'd0;
        out_rptr   <= 4'd0;
        in_count   <= 3'd0;
        in_wrapped <= 1'b0;
        ovf        <= 1'b0;
      end else begin
        if (wr_mem_in) begin
          in_wptr <= in_wptr + 4'd1;
          if (in_wptr == 4'd15) in_wrapped <= 1'b1;
          if (in_count != 3'd7) in_count <= in_count + 3'd1;
        end
        // A write landing on a wrapped buffer overwrites unread data.
        if (wr_mem_in && in_wrapped)         ovf <= 1'b1;
        else if (wr_status && aip_datain[5]) ovf <= 1'b0;
        if (rd_mem_out) out_rptr <= out_rptr + 4'd1;
      end
    end
  end

  // NOTE: buffer storage has no reset; its contents after reset are don't-care,
  // and leaving it out lets the arrays map onto plain RAM.
  always_ff @(posedge clk_clk) begin
    if (wr_mem_in) in_mem[in_wptr] <= aip_datain;
    if (out_we && (state_q == ST_RUN)) out_mem[out_wraddr] <= out_wrdata;
  end

endmodule

// File: tb/tb_aip_responder.sv
// Directed self-checking bench for aip_responder: register access, launch/complete handshake,
// overflow, ignored starts and reset during RUN.
module tb_aip_responder;

  logic        clk_clk = 1'b0;
  logic        reset;
  logic [4:0]  aip_config;
  logic [31:0] aip_datain;
  logic        aip_write, aip_read, aip_start, core_int;
  logic [31:0] aip_dataout;
  logic        aip_int, core_start;
  logic [31:0] core_cfg;
  logic        core_done, core_busy;
  logic [3:0]  in_rdaddr;
  logic [31:0] in_rddata;
  logic        out_we;
  logic [3:0]  out_wraddr;
  logic [31:0] out_wrdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rd;

`ifdef AIP_RESPONDER_ID_EN
  localparam logic [31:0] ID_EXP = 32'h00A1_2001;
`else
  localparam logic [31:0] ID_EXP = 32'h0;
`endif

  aip_responder dut (
    .clk_clk(clk_clk), .reset(reset), .aip_config(aip_config), .aip_datain(aip_datain),
    .aip_write(aip_write), .aip_read(aip_read), .aip_start(aip_start), .core_int(core_int),
    .aip_dataout(aip_dataout), .aip_int(aip_int), .core_start(core_start), .core_cfg(core_cfg),
    .core_done(core_done), .core_busy(core_busy), .in_rdaddr(in_rdaddr), .in_rddata(in_rddata),
    .out_we(out_we), .out_wraddr(out_wraddr), .out_wrdata(out_wrdata)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
    aip_config = addr;
    aip_datain = data;
    aip_write  = 1'b1;
    tick();
    aip_write  = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] addr, output logic [31:0] data);
    aip_config = addr;
    aip_read   = 1'b1;
    tick();
    aip_read   = 1'b0;
    data       = aip_dataout;
  endtask

  task automatic core_write(input logic [3:0] addr, input logic [31:0] data);
    out_wraddr = addr;
    out_wrdata = data;
    out_we     = 1'b1;
    tick();
    out_we     = 1'b0;
  endtask

  task automatic pulse_start();
    aip_start = 1'b1;
    tick();
    aip_start = 1'b0;
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    aip_config = '0; aip_datain = '0; aip_write = 0; aip_read = 0; aip_start = 0;
    core_int = 0; core_done = 0; core_busy = 0; in_rdaddr = '0;
    out_we = 0; out_wraddr = '0; out_wrdata = '0;
    #1;
    check("rst_dataout", aip_dataout, 32'h0);
    check("rst_int", {31'b0, aip_int}, 32'h0);
    check("rst_core_start", {31'b0, core_start}, 32'h0);
    check("rst_cfg", core_cfg, 32'h0);
    tick(); tick();
    reset = 1'b0;
    tick();

    bus_read(5'h1F, rd);            check("status_after_rst", rd, 32'h0);

    bus_write(5'h02, 32'h1234_5678);
    bus_read(5'h02, rd);            check("cfg_read", rd, 32'h1234_5678);
    check("core_cfg", core_cfg, 32'h1234_5678);
    tick();
    check("dataout_hold", aip_dataout, 32'h1234_5678);

    // Simultaneous write and read of CFG returns the old value.
    aip_config = 5'h02; aip_datain = 32'hCAFE_F00D; aip_write = 1; aip_read = 1;
    tick();
    aip_write = 0; aip_read = 0;
    check("cfg_rw_old", aip_dataout, 32'h1234_5678);
    check("cfg_rw_new", core_cfg, 32'hCAFE_F00D);

    bus_write(5'h05, 32'hFFFF_FFFF);
    bus_read(5'h05, rd);            check("unused_code", rd, 32'h0);
    bus_read(5'h1E, rd);            check("id_reg", rd, ID_EXP);
    bus_read(5'h00, rd);            check("mem_in_wo", rd, 32'h0);

    bus_write(5'h00, 32'hA);
    bus_write(5'h00, 32'hB);
    bus_write(5'h00, 32'hC);
    bus_read(5'h1F, rd);            check("status_count3", rd, 32'h3);

    aip_start = 1'b1;
    tick();
    aip_start = 1'b0;
    check("start_pulse", {31'b0, core_start}, 32'h1);
    core_busy = 1'b1;
    tick();
    check("start_one_cycle", {31'b0, core_start}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] exp_in;
      exp_in = 32'hA + i;
      in_rdaddr = i[3:0];
      #1;
      check($sformatf("in_rd%0d", i), in_rddata, exp_in);
    end
    bus_read(5'h1F, rd);            check("status_run_busy", rd, 32'h10);

    pulse_start();
    check("start_in_run", {31'b0, core_start}, 32'h0);

    core_write(4'd0, 32'h55);
    core_write(4'd1, 32'h66);
    core_write(4'd2, 32'h77);
    core_busy = 1'b0;
    core_done = 1'b1;
    #1;
    check("int_before_done", {31'b0, aip_int}, 32'h0);
    tick();
    core_done = 1'b0;
    check("int_after_done", {31'b0, aip_int}, 32'h1);
    bus_read(5'h1F, rd);            check("status_done", rd, 32'h08);

    core_write(4'd2, 32'h99);
    pulse_start();
    check("start_in_done", {31'b0, core_start}, 32'h0);
    bus_read(5'h01, rd);            check("mem_out0", rd, 32'h55);
    bus_read(5'h01, rd);            check("mem_out1", rd, 32'h66);
    bus_read(5'h01, rd);            check("mem_out2_we_ignored", rd, 32'h77);

    core_int = 1'b1;
    tick();
    core_int = 1'b0;
    check("int_cleared", {31'b0, aip_int}, 32'h0);

    for (int i = 0; i < 17; i++) bus_write(5'h00, 32'h100 + i);
    bus_read(5'h1F, rd);            check("status_ovf", rd, 32'h27);

    pulse_start();
    check("start2_pulse", {31'b0, core_start}, 32'h1);
    in_rdaddr = 4'd0; #1;           check("ovf_entry0", in_rddata, 32'h110);
    in_rdaddr = 4'd1; #1;           check("ovf_entry1", in_rddata, 32'h101);
    bus_read(5'h1F, rd);            check("status_cleared_on_start", rd, 32'h0);

    pulse_done();
    check("int_run2", {31'b0, aip_int}, 32'h1);
    core_done = 1'b1; core_int = 1'b1;
    tick();
    core_done = 1'b0; core_int = 1'b0;
    check("ack_priority", {31'b0, aip_int}, 32'h0);
    bus_read(5'h1F, rd);            check("status_idle", rd, 32'h0);

    core_busy = 1'b1;
    pulse_start();
    check("start_while_busy", {31'b0, core_start}, 32'h0);
    bus_read(5'h1F, rd);            check("status_idle_busy", rd, 32'h10);
    core_busy = 1'b0;

    pulse_start();
    check("start3_pulse", {31'b0, core_start}, 32'h1);
    pulse_done();
    check("int_run3", {31'b0, aip_int}, 32'h1);
    bus_write(5'h1F, 32'h2);
    check("status_w1c_ack", {31'b0, aip_int}, 32'h0);

    pulse_done();
    check("done_in_idle", {31'b0, aip_int}, 32'h0);

    bus_read(5'h02, rd);            check("cfg_before_rst", rd, 32'hCAFE_F00D);
    aip_start = 1'b1;
    tick();
    aip_start = 1'b0;
    check("start4_pulse", {31'b0, core_start}, 32'h1);
    reset = 1'b1;
    #1;
    check("rrun_core_start", {31'b0, core_start}, 32'h0);
    check("rrun_int", {31'b0, aip_int}, 32'h0);
    check("rrun_dataout", aip_dataout, 32'h0);
    check("rrun_cfg", core_cfg, 32'h0);
    tick();
    reset = 1'b0;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("rrun_no_int", {31'b0, aip_int}, 32'h0);
    check("rrun_no_start", {31'b0, core_start}, 32'h0);
    bus_read(5'h1F, rd);            check("rrun_status_idle", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aip_responder.md
AIP_RESPONDER -- requirements
Module: aip_responder

Interface
REQ-001 SHALL have port clk_clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port aip_config, input, 5 bits: register select from the master.
REQ-004 SHALL have port aip_datain, input, 32 bits: write data from the master.
REQ-005 SHALL have ports aip_write and aip_read, each input, 1 bit: single-cycle access strobes.
REQ-006 SHALL have port aip_start, input, 1 bit: start request for the core.
REQ-007 SHALL have port core_int, input, 1 bit: master interrupt acknowledge; clears DONE.
REQ-008 SHALL have port aip_dataout, output, 32 bits: registered read data.
REQ-009 SHALL have port aip_int, output, 1 bit: interrupt to the master.
REQ-010 SHALL have ports core_start, output, 1 bit, and core_cfg, output, 32 bits: core launch pulse and CFG register.
REQ-011 SHALL have ports core_done, input, 1 bit (completion pulse), and core_busy, input, 1 bit.
REQ-012 SHALL have ports in_rdaddr, input, 4 bits, and in_rddata, output, 32 bits: combinational core read port of the input buffer.
REQ-013 SHALL have ports out_we, input, 1 bit; out_wraddr, input, 4 bits; out_wrdata, input, 32 bits: core write port of the output buffer.

Function
REQ-014 SHALL decode aip_config: 0x00 MEM_IN (write-only), 0x01 MEM_OUT (read-only), 0x02 CFG (read/write), 0x1E ID (read-only), 0x1F STATUS (read; write-1-to-clear); all other codes read 0, and writes to them are ignored.
REQ-015 SHALL store each aip_write to MEM_IN at in_wptr, then increment in_wptr modulo 16; the 17th write overwrites entry 0 and sets STATUS.OVF.
REQ-016 SHALL return out[out_rptr] on aip_dataout the cycle after an aip_read of MEM_OUT, then increment out_rptr modulo 16.
REQ-017 SHALL have a read latency of exactly one cycle; aip_dataout SHALL hold its value until the next aip_read.
REQ-018 SHALL format STATUS as {26'b0, OVF, BUSY, DONE, in_count[2:0]}, with in_count saturating at 7 and BUSY = core_busy.
REQ-019 SHALL use a three-state FSM: IDLE -> RUN on aip_start with core_busy=0; RUN -> DONE on core_done; DONE -> IDLE on core_int or on a STATUS write with bit1=1.
REQ-020 SHALL pulse core_start high for exactly one cycle on the IDLE->RUN transition and SHALL clear in_wptr, out_rptr, in_count and OVF in the same cycle.
REQ-021 SHALL ignore aip_start outside IDLE, or while core_busy=1.
REQ-022 SHALL assert aip_int iff the state is DONE, registered, i.e. one cycle after core_done.
REQ-023 SHALL give core_done and the acknowledge priority to the acknowledge when they occur in the same cycle in state DONE; core_done in IDLE SHALL be ignored.
REQ-024 SHALL, when aip_write and aip_read are asserted in the same cycle, perform both; a read of CFG in that cycle SHALL return the old value.
REQ-025 SHALL accept an out_we during RUN only; out_we in any other state SHALL be ignored.

Reset
REQ-026 SHALL, on reset, force: state IDLE; aip_dataout=0; aip_int=0; core_start=0; CFG=0; pointers, in_count and OVF=0; buffer contents unspecified.
REQ-027 SHALL, on reset during RUN, abandon the operation with no aip_int and no core_start.

Configuration
REQ-028 SHALL implement the ID register at 0x1E, returning 32'h00A1_2001, when macro AIP_RESPONDER_ID_EN is defined; without the macro, 0x1E SHALL read 0 like an unused code.

Verification
REQ-029 Write CFG=0x1234_5678, then read CFG -> aip_dataout=0x1234_5678 one cycle after aip_read; core_cfg matches.
REQ-030 Write 3 words to MEM_IN (0xA, 0xB, 0xC), then pulse aip_start -> one core_start pulse; in_rdaddr 0..2 return 0xA, 0xB, 0xC; STATUS in_count=0 after start.
REQ-031 Core writes out[0]=0x55 and out[1]=0x66, then pulses core_done -> aip_int=1 next cycle; two MEM_OUT reads return 0x55, then 0x66; core_int pulse -> aip_int=0 next cycle.
REQ-032 17 MEM_IN writes -> STATUS.OVF=1, in_count=7, entry 0 holds the 17th value.
REQ-033 aip_start in RUN, or with core_busy=1 -> no core_start; assert reset in RUN -> state IDLE, all outputs 0 immediately.
REQ-034 Read 0x1E -> 0x00A1_2001 with AIP_RESPONDER_ID_EN defined, 0 without it.
